// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit five-stage core.
// Condition codes, opcodes, flag indices and the PC-control states.
package cpu_pkg;

   typedef enum logic [2:0] {
      CC_NEQ    = 3'b000,
      CC_EQ     = 3'b001,
      CC_GT     = 3'b010,
      CC_LT     = 3'b011,
      CC_GTE    = 3'b100,
      CC_LTE    = 3'b101,
      CC_OVFL   = 3'b110,
      CC_UNCOND = 3'b111
   } ccc_e;

   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_PCS = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HALTING = 2'd1,
      HALTED  = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_target_gen.sv
// Branch condition evaluation and B/BR target formation.
// Purely combinational; consumed by pc_control in the ID stage.
module pc_target_gen
   import cpu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_is_br,
   input  logic [2:0]       i_ccc,
   input  logic [2:0]       i_flags,
   input  logic [8:0]       i_imm9,
   input  logic [WIDTH-1:0] i_rs_data,
   input  logic [WIDTH-1:0] i_pc_plus2,
   output logic             o_taken,
   output logic [WIDTH-1:0] o_target
);

   logic             w_n;
   logic             w_v;
   logic             w_z;
   logic [WIDTH-1:0] w_off;
   logic [WIDTH-1:0] w_b_tgt;
   logic [WIDTH-1:0] w_br_tgt;

   assign w_n = i_flags[FLAG_N];
   assign w_v = i_flags[FLAG_V];
   assign w_z = i_flags[FLAG_Z];

   always_comb begin
      o_taken = 1'b0;
      unique case (ccc_e'(i_ccc))
         CC_NEQ:    o_taken = !w_z;
         CC_EQ:     o_taken = w_z;
         CC_GT:     o_taken = !w_z && !w_n;
         CC_LT:     o_taken = w_n;
         CC_GTE:    o_taken = w_z || !w_n;
         CC_LTE:    o_taken = w_n || w_z;
         CC_OVFL:   o_taken = w_v;
         CC_UNCOND: o_taken = 1'b1;
         default:   o_taken = 1'b0;
      endcase
   end

   // Word offset: sign-extend and scale to bytes
   assign w_off    = {{(WIDTH-10){i_imm9[8]}}, i_imm9, 1'b0};
   assign w_b_tgt  = i_pc_plus2 + w_off;
   assign w_br_tgt = {i_rs_data[WIDTH-1:1], 1'b0};
   assign o_target = i_is_br ? w_br_tgt : w_b_tgt;

endmodule

// File: rtl/pc_control.sv
// Program counter, next-PC selection, halt sequencing and branch
// perf counters for the 16-bit core; branches resolve in ID.
module pc_control
   import cpu_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             if_hlt,
   input  logic             wb_hlt,
   input  logic             id_valid,
   input  logic             id_is_b,
   input  logic             id_is_br,
   input  logic [2:0]       id_ccc,
   input  logic [8:0]       id_imm9,
   input  logic [WIDTH-1:0] id_rs_data,
   input  logic [WIDTH-1:0] id_pc_plus2,
   input  logic [2:0]       flag_reg,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus2,
   output logic             flush,
   output logic             halted,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   pc_state_e        r_state;
   pc_state_e        w_st_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [CNT_W-1:0] r_br;
   logic [CNT_W-1:0] r_tk;
   logic             r_halted;
   logic             w_taken;
   logic [WIDTH-1:0] w_target;
   logic             w_resolve;
   logic             w_redirect;

   pc_target_gen #(.WIDTH(WIDTH)) u_tgt (
      .i_is_br    (id_is_br),
      .i_ccc      (id_ccc),
      .i_flags    (flag_reg),
      .i_imm9     (id_imm9),
      .i_rs_data  (id_rs_data),
      .i_pc_plus2 (id_pc_plus2),
      .o_taken    (w_taken),
      .o_target   (w_target)
   );

   // Everything is ignored once halted
   assign w_resolve  = id_valid && (id_is_b || id_is_br) && !stall
                       && (r_state != HALTED);
   assign w_redirect = w_resolve && w_taken;

   always_comb begin
      w_pc_nxt = r_pc;
      w_st_nxt = r_state;
      unique case (r_state)
         RUN: begin
            if (w_redirect)  w_pc_nxt = w_target;
            else if (stall)  w_pc_nxt = r_pc;
            else if (if_hlt) w_st_nxt = HALTING;
            else             w_pc_nxt = r_pc + WIDTH'(2);
         end
         HALTING: begin
            if (w_redirect) begin
               w_pc_nxt = w_target;
               w_st_nxt = RUN;
            end else if (wb_hlt) begin
               w_st_nxt = HALTED;
            end
         end
         HALTED:  w_st_nxt = HALTED;
         default: w_st_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= RUN;
         r_pc     <= {RESET_PC[WIDTH-1:1], 1'b0};
         r_halted <= 1'b0;
         r_br     <= '0;
         r_tk     <= '0;
      end else begin
         r_state  <= w_st_nxt;
         r_pc     <= w_pc_nxt;
         r_halted <= (w_st_nxt == HALTED);
         if (w_resolve && (r_br != '1))
            r_br <= r_br + CNT_W'(1);
         if (w_redirect && (r_tk != '1))
            r_tk <= r_tk + CNT_W'(1);
      end
   end

   assign pc          = r_pc;
   assign pc_plus2    = r_pc + WIDTH'(2);
   assign flush       = w_redirect && !rst;
   assign halted      = r_halted;
   assign br_count    = r_br;
   assign taken_count = r_tk;

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: per-cycle model compare plus
// directed vectors with hand-computed expectations.
module tb_pc_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        if_hlt;
   logic        wb_hlt;
   logic        id_valid;
   logic        id_is_b;
   logic        id_is_br;
   logic [2:0]  id_ccc;
   logic [8:0]  id_imm9;
   logic [15:0] id_rs_data;
   logic [15:0] id_pc_plus2;
   logic [2:0]  flag_reg;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        flush;
   logic        halted;
   logic [15:0] br_count;
   logic [15:0] taken_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_control dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .if_hlt      (if_hlt),
      .wb_hlt      (wb_hlt),
      .id_valid    (id_valid),
      .id_is_b     (id_is_b),
      .id_is_br    (id_is_br),
      .id_ccc      (id_ccc),
      .id_imm9     (id_imm9),
      .id_rs_data  (id_rs_data),
      .id_pc_plus2 (id_pc_plus2),
      .flag_reg    (flag_reg),
      .pc          (pc),
      .pc_plus2    (pc_plus2),
      .flush       (flush),
      .halted      (halted),
      .br_count    (br_count),
      .taken_count (taken_count)
   );

   // Behavioural model
   bit        m_ok = 1'b0;
   bit [15:0] m_pc;
   bit        m_halting;
   bit        m_halted;
   int        m_br;
   int        m_tk;

   function automatic bit m_taken(input bit [2:0] c, input bit [2:0] f);
      bit n, v, z;
      n = f[2]; v = f[1]; z = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit [15:0] m_target();
      int off;
      if (id_is_br) return id_rs_data & 16'hFFFE;
      off = $signed(id_imm9);
      return 16'(int'(id_pc_plus2) + off * 2);
   endfunction

   function automatic bit m_resolve();
      return id_valid && (id_is_b || id_is_br) && !stall && !m_halted;
   endfunction

   function automatic bit m_redirect();
      return m_resolve() && m_taken(id_ccc, flag_reg);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ok = 1'b1;
         m_pc = 16'h0000;
         m_halting = 1'b0;
         m_halted = 1'b0;
         m_br = 0;
         m_tk = 0;
      end else if (m_ok && !m_halted) begin
         if (m_resolve()) m_br = (m_br < 65535) ? m_br + 1 : 65535;
         if (m_redirect()) begin
            m_tk = (m_tk < 65535) ? m_tk + 1 : 65535;
            m_pc = m_target();
            m_halting = 1'b0;
         end else if (m_halting) begin
            if (wb_hlt) begin
               m_halting = 1'b0;
               m_halted = 1'b1;
            end
         end else if (!stall) begin
            if (if_hlt) m_halting = 1'b1;
            else m_pc = m_pc + 16'd2;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad < 40)
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_ok) begin
         chk("pc", 32'(pc), 32'(m_pc));
         chk("pc_plus2", 32'(pc_plus2), 32'(16'(m_pc + 16'd2)));
         chk("flush", 32'(flush), 32'(!rst && m_redirect()));
         chk("halted", 32'(halted), 32'(m_halted));
         chk("br_count", 32'(br_count), 32'(m_br));
         chk("taken_count", 32'(taken_count), 32'(m_tk));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; if_hlt = 0; wb_hlt = 0; id_valid = 0;
      id_is_b = 0; id_is_br = 0; id_ccc = 0; id_imm9 = 0;
      id_rs_data = 0; id_pc_plus2 = 0; flag_reg = 0;
   endtask

   task automatic br_to(input logic [15:0] rs);
      idle();
      id_valid = 1; id_is_br = 1; id_ccc = 3'b111; id_rs_data = rs;
   endtask

   initial begin
      idle();
      rst = 1;
      cyc();
      cyc();
      rst = 0;
      chk("rst_pc", 32'(pc), 32'h0000);
      chk("rst_halted", 32'(halted), 32'h0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("run_pc", 32'(pc), 32'(2 * i));
      end

      // B EQ taken, then not taken
      id_valid = 1; id_is_b = 1; id_ccc = 3'b001; flag_reg = 3'b001;
      id_pc_plus2 = 16'h0010; id_imm9 = 9'h1FE;
      #1 chk("b_flush", 32'(flush), 32'h1);
      cyc();
      chk("b_pc", 32'(pc), 32'h000C);
      chk("b_tk", 32'(taken_count), 32'h1);
      flag_reg = 3'b000;
      #1 chk("bnt_flush", 32'(flush), 32'h0);
      cyc();
      chk("bnt_pc", 32'(pc), 32'h000E);
      chk("bnt_br", 32'(br_count), 32'h2);
      chk("bnt_tk", 32'(taken_count), 32'h1);

      // BR under stall, then released
      br_to(16'h1235);
      stall = 1;
      #1 chk("br_stall_flush", 32'(flush), 32'h0);
      cyc();
      chk("br_stall_pc", 32'(pc), 32'h000E);
      stall = 0;
      #1 chk("br_flush", 32'(flush), 32'h1);
      cyc();
      chk("br_pc", 32'(pc), 32'h1234);
      chk("br_br", 32'(br_count), 32'h3);

      // Halt sequence at 0x0020
      br_to(16'h0020);
      cyc();
      idle();
      if_hlt = 1;
      cyc();
      if_hlt = 0;
      chk("hlt_pc", 32'(pc), 32'h0020);
      cyc();
      cyc();
      wb_hlt = 1;
      cyc();
      wb_hlt = 0;
      chk("halted", 32'(halted), 32'h1);
      br_to(16'h4444);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("halted_hold", 32'(halted), 32'h1);
         chk("halted_pc", 32'(pc), 32'h0020);
      end
      idle();
      rst = 1;
      cyc();
      rst = 0;
      chk("rst2_pc", 32'(pc), 32'h0000);
      chk("rst2_halted", 32'(halted), 32'h0);
      chk("rst2_br", 32'(br_count), 32'h0);

      // Taken B cancels HALTING
      if_hlt = 1;
      cyc();
      idle();
      id_valid = 1; id_is_b = 1; id_ccc = 3'b010; flag_reg = 3'b000;
      id_pc_plus2 = 16'h0040; id_imm9 = 9'h008;
      cyc();
      chk("unhalt_pc", 32'(pc), 32'h0050);
      idle();
      cyc();
      chk("unhalt_run", 32'(pc), 32'h0052);
      chk("unhalt_halted", 32'(halted), 32'h0);

      // Wrap through top of address space; stray wb_hlt ignored
      br_to(16'hFFFD);
      cyc();
      chk("top_pc", 32'(pc), 32'hFFFC);
      idle();
      wb_hlt = 1;
      cyc();
      wb_hlt = 0;
      chk("wrap1", 32'(pc), 32'hFFFE);
      cyc();
      chk("wrap2", 32'(pc), 32'h0000);

      // Saturate br_count with not-taken branches
      id_valid = 1; id_is_b = 1; id_ccc = 3'b001; flag_reg = 3'b000;
      for (int i = 0; i < 65540; i++) cyc();
      chk("br_sat", 32'(br_count), 32'hFFFF);
      chk("tk_sat", 32'(taken_count), 32'h2);
      idle();
      cyc();
      chk("br_sat_hold", 32'(br_count), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
